// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard controller and the control decoder.
package hazard_pkg;

    // Operand not read by the instruction.
    localparam int TUSE_NONE = 16;
    // Lowest T code meaning "no register write"; anything at or above it is equivalent.
    localparam int TNEW_NOWR = 3;

    // Result-ready stage codes.
    localparam logic [1:0] T_D = 2'd0;
    localparam logic [1:0] T_E = 2'd1;
    localparam logic [1:0] T_M = 2'd2;

    // Forward select encoding shared by all mux selects.
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority matcher: picks the youngest enabled stage whose destination equals
// the operand. A match on a stage whose result is not ready yet yields FWD_RF,
// because an older stage holds a stale value for that register.
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_op,
    input  logic [2:0] i_en,        // bit0 = E, bit1 = M, bit2 = W
    input  logic [4:0] i_e_dst,
    input  logic [1:0] i_e_tnew,
    input  logic [4:0] i_m_dst,
    input  logic [1:0] i_m_tnew,
    input  logic [4:0] i_w_dst,
    output logic [1:0] o_sel
);

    logic w_op_nz;
    logic w_hit_e;
    logic w_hit_m;
    logic w_hit_w;

    assign w_op_nz = (i_op != 5'd0);
    assign w_hit_e = i_en[0] && w_op_nz && (i_op == i_e_dst);
    assign w_hit_m = i_en[1] && w_op_nz && (i_op == i_m_dst);
    assign w_hit_w = i_en[2] && w_op_nz && (i_op == i_w_dst);

    // Youngest matching stage decides the select.
    always_comb begin
        o_sel = FWD_RF;
        if (w_hit_e) begin
            o_sel = (i_e_tnew == 2'd0) ? FWD_E : FWD_RF;
        end else if (w_hit_m) begin
            o_sel = (i_m_tnew == 2'd0) ? FWD_M : FWD_RF;
        end else if (w_hit_w) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall and forwarding controller for the five-stage MIPS pipeline. Keeps a
// shadow of destination/Tnew for E, M and W and compares it with the Tuse
// fields of the instruction currently in D.
module hazard_unit #(
    parameter int TUSE_NONE = hazard_pkg::TUSE_NONE,
    parameter int TNEW_NOWR = hazard_pkg::TNEW_NOWR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rs_tuse,
    input  logic [4:0] d_rt_tuse,
    input  logic [4:0] d_t,
    input  logic [4:0] d_dst,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic [1:0] fwd_m_rt
);

    logic [4:0] r_e_dst;
    logic [1:0] r_e_tnew;
    logic [4:0] r_e_rs;
    logic [4:0] r_e_rt;
    logic [4:0] r_m_dst;
    logic [1:0] r_m_tnew;
    logic [4:0] r_m_rt;
    logic [4:0] r_w_dst;

    logic       w_d_wr;
    logic [4:0] w_d_dst_eff;
    logic [1:0] w_d_tnew;
    logic       w_rs_hit;
    logic       w_rt_hit;

    // Register 0 and non-writing instructions carry no destination into the pipe.
    assign w_d_wr      = (d_t < 5'(TNEW_NOWR)) && (d_dst != 5'd0);
    assign w_d_dst_eff = w_d_wr ? d_dst : 5'd0;
    assign w_d_tnew    = w_d_wr ? d_t[1:0] : 2'd0;

    // An operand stalls when its producer in E or M will not have the value in time.
    assign w_rs_hit = (d_rs_tuse != 5'(TUSE_NONE)) && (d_rs != 5'd0) &&
                      (((d_rs == r_e_dst) && (d_rs_tuse < {3'd0, r_e_tnew})) ||
                       ((d_rs == r_m_dst) && (d_rs_tuse < {3'd0, r_m_tnew})));
    assign w_rt_hit = (d_rt_tuse != 5'(TUSE_NONE)) && (d_rt != 5'd0) &&
                      (((d_rt == r_e_dst) && (d_rt_tuse < {3'd0, r_e_tnew})) ||
                       ((d_rt == r_m_dst) && (d_rt_tuse < {3'd0, r_m_tnew})));
    assign stall = w_rs_hit || w_rt_hit;

    // Pipeline shadow: E takes a bubble on stall, M and W always drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e_dst  <= 5'd0;
            r_e_tnew <= 2'd0;
            r_e_rs   <= 5'd0;
            r_e_rt   <= 5'd0;
            r_m_dst  <= 5'd0;
            r_m_tnew <= 2'd0;
            r_m_rt   <= 5'd0;
            r_w_dst  <= 5'd0;
        end else begin
            if (stall) begin
                r_e_dst  <= 5'd0;
                r_e_tnew <= 2'd0;
                r_e_rs   <= 5'd0;
                r_e_rt   <= 5'd0;
            end else begin
                r_e_dst  <= w_d_dst_eff;
                r_e_tnew <= w_d_tnew;
                r_e_rs   <= d_rs;
                r_e_rt   <= d_rt;
            end
            r_m_dst  <= r_e_dst;
            r_m_tnew <= (r_e_tnew == 2'd0) ? 2'd0 : r_e_tnew - 2'd1;
            r_m_rt   <= r_e_rt;
            r_w_dst  <= r_m_dst;
        end
    end

    hazard_fwd_sel u_fwd_d_rs (
        .i_op(d_rs), .i_en(3'b111),
        .i_e_dst(r_e_dst), .i_e_tnew(r_e_tnew),
        .i_m_dst(r_m_dst), .i_m_tnew(r_m_tnew),
        .i_w_dst(r_w_dst), .o_sel(fwd_d_rs)
    );

    hazard_fwd_sel u_fwd_d_rt (
        .i_op(d_rt), .i_en(3'b111),
        .i_e_dst(r_e_dst), .i_e_tnew(r_e_tnew),
        .i_m_dst(r_m_dst), .i_m_tnew(r_m_tnew),
        .i_w_dst(r_w_dst), .o_sel(fwd_d_rt)
    );

    hazard_fwd_sel u_fwd_e_rs (
        .i_op(r_e_rs), .i_en(3'b110),
        .i_e_dst(r_e_dst), .i_e_tnew(r_e_tnew),
        .i_m_dst(r_m_dst), .i_m_tnew(r_m_tnew),
        .i_w_dst(r_w_dst), .o_sel(fwd_e_rs)
    );

    hazard_fwd_sel u_fwd_e_rt (
        .i_op(r_e_rt), .i_en(3'b110),
        .i_e_dst(r_e_dst), .i_e_tnew(r_e_tnew),
        .i_m_dst(r_m_dst), .i_m_tnew(r_m_tnew),
        .i_w_dst(r_w_dst), .o_sel(fwd_e_rt)
    );

    hazard_fwd_sel u_fwd_m_rt (
        .i_op(r_m_rt), .i_en(3'b100),
        .i_e_dst(r_e_dst), .i_e_tnew(r_e_tnew),
        .i_m_dst(r_m_dst), .i_m_tnew(r_m_tnew),
        .i_w_dst(r_w_dst), .o_sel(fwd_m_rt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed hazard scenarios plus randomized traffic
// compared against an issue-history model of the pipeline.
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_t, d_dst;
    logic       stall;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .d_rs(d_rs), .d_rt(d_rt),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse),
        .d_t(d_t), .d_dst(d_dst),
        .stall(stall),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .fwd_m_rt(fwd_m_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the last three issue slots (0 = now in E, 1 = M, 2 = W).
    typedef struct {
        int dst;
        int t;
        int rs;
        int rt;
    } slot_t;

    slot_t hist[3];

    function automatic int tnew_of(int k);
        int v;
        if (hist[k].dst == 0 || k == 2) return 0;
        v = hist[k].t - k;
        return (v < 0) ? 0 : v;
    endfunction

    function automatic bit op_stall(int op, int tuse);
        if (tuse == 16 || op == 0) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (hist[k].dst == op && tuse < tnew_of(k)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return op_stall(int'(d_rs), int'(d_rs_tuse)) || op_stall(int'(d_rt), int'(d_rt_tuse));
    endfunction

    // Youngest producer at or after stage 'first' decides; not-ready means no forward.
    function automatic int m_fwd(int op, int first);
        if (op == 0) return 0;
        for (int k = first; k < 3; k++)
            if (hist[k].dst == op) return (tnew_of(k) == 0) ? k + 1 : 0;
        return 0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) hist[k] = '{0, 0, 0, 0};
    endtask

    task automatic model_advance();
        slot_t s;
        if (m_stall()) s = '{0, 0, 0, 0};
        else begin
            s.dst = (d_t < 3 && d_dst != 0) ? int'(d_dst) : 0;
            s.t   = int'(d_t);
            s.rs  = int'(d_rs);
            s.rt  = int'(d_rt);
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = s;
    endtask

    task automatic set_d(int rs, int rt, int trs, int trt, int t, int dst);
        d_rs = 5'(rs); d_rt = 5'(rt);
        d_rs_tuse = 5'(trs); d_rt_tuse = 5'(trt);
        d_t = 5'(t); d_dst = 5'(dst);
        #1;
    endtask

    task automatic idle();
        set_d(0, 0, 16, 16, 3, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_clear();
        else model_advance();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_clear();
        set_d(5, 5, 0, 0, 2, 5);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_checks++;
        if ({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt} !== 10'd0) begin
            n_fail++; $display("FAIL reset_fwd: got %h want 0", {fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt});
        end
        rst_n = 1'b1;
        idle();
        for (int c = 0; c < 4; c++) begin
            tick();
            // Probe every register number: any residual state would show up.
            for (int r = 1; r < 32; r++) begin
                set_d(r, r, 0, 0, 3, 0);
                n_checks++;
                if (stall !== 1'b0 || fwd_d_rs !== 2'd0 || fwd_e_rs !== 2'd0 || fwd_m_rt !== 2'd0) begin
                    n_fail++; $display("FAIL reset_idle_state: r=%0d stall=%0b fd=%0d fe=%0d fm=%0d want 0", r, stall, fwd_d_rs, fwd_e_rs, fwd_m_rt);
                end
            end
            idle();
        end
    endtask

    task automatic test_lw_beq();
        do_reset();
        set_d(1, 0, 1, 16, 2, 8);
        tick();
        set_d(8, 0, 0, 16, 3, 0);
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_beq_stall%0d: got %0b want 1", c, stall); end
            tick();
        end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_beq_release: got %0b want 0", stall); end
        n_checks++;
        if (fwd_d_rs !== 2'd3) begin n_fail++; $display("FAIL lw_beq_fwd: got %0d want 3", fwd_d_rs); end
        tick();
        idle();
    endtask

    task automatic test_alu_rtype();
        do_reset();
        set_d(1, 2, 1, 1, 1, 9);
        tick();
        set_d(3, 9, 1, 1, 1, 11);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_rtype_stall: got %0b want 0", stall); end
        tick();
        idle();
        n_checks++;
        if (fwd_e_rt !== 2'd2) begin n_fail++; $display("FAIL alu_rtype_fwd_e_rt: got %0d want 2", fwd_e_rt); end
        n_checks++;
        if (fwd_e_rs !== 2'd0) begin n_fail++; $display("FAIL alu_rtype_fwd_e_rs: got %0d want 0", fwd_e_rs); end
        tick();
    endtask

    task automatic test_alu_beq();
        do_reset();
        set_d(1, 2, 1, 1, 1, 7);
        tick();
        set_d(7, 0, 0, 16, 3, 0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL alu_beq_stall: got %0b want 1", stall); end
        tick();
        n_checks++;
        if (stall !== 1'b0 || fwd_d_rs !== 2'd2) begin
            n_fail++; $display("FAIL alu_beq_release: stall=%0b fwd=%0d want 0/2", stall, fwd_d_rs);
        end
        tick();
        idle();
    endtask

    task automatic test_w_forward();
        do_reset();
        set_d(1, 0, 1, 16, 1, 10);
        tick();
        set_d(1, 2, 1, 1, 1, 12);
        tick();
        set_d(10, 0, 1, 16, 1, 13);
        n_checks++;
        if (stall !== 1'b0 || fwd_d_rs !== 2'd2) begin
            n_fail++; $display("FAIL w_fwd_d: stall=%0b fwd_d_rs=%0d want 0/2", stall, fwd_d_rs);
        end
        tick();
        idle();
        n_checks++;
        if (fwd_e_rs !== 2'd3) begin n_fail++; $display("FAIL w_fwd_e_rs: got %0d want 3", fwd_e_rs); end
        tick();
    endtask

    task automatic test_lw_sw();
        do_reset();
        set_d(1, 0, 1, 16, 2, 4);
        tick();
        set_d(29, 4, 1, 2, 3, 0);
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_sw_stall: got %0b want 0", stall); end
        tick();
        idle();
        n_checks++;
        if (fwd_e_rt !== 2'd0) begin n_fail++; $display("FAIL lw_sw_fwd_e_rt: got %0d want 0", fwd_e_rt); end
        tick();
        n_checks++;
        if (fwd_m_rt !== 2'd3) begin n_fail++; $display("FAIL lw_sw_fwd_m_rt: got %0d want 3", fwd_m_rt); end
        tick();
    endtask

    task automatic test_zero_dst();
        do_reset();
        set_d(1, 2, 1, 1, 1, 0);
        tick();
        set_d(0, 0, 0, 0, 3, 0);
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (stall !== 1'b0 || fwd_d_rs !== 2'd0 || fwd_d_rt !== 2'd0) begin
                n_fail++; $display("FAIL zero_dst c%0d: stall=%0b fwd_d_rs=%0d fwd_d_rt=%0d want 0", c, stall, fwd_d_rs, fwd_d_rt);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_d(1, 2, 1, 1, 1, 5);
        tick();
        set_d(3, 4, 1, 1, 1, 5);
        tick();
        // Two producers of $5 in flight: E not ready yet, so no forward from M.
        set_d(5, 0, 1, 16, 1, 6);
        n_checks++;
        if (stall !== 1'b0 || fwd_d_rs !== 2'd0) begin
            n_fail++; $display("FAIL b2b_d: stall=%0b fwd_d_rs=%0d want 0/0", stall, fwd_d_rs);
        end
        tick();
        idle();
        n_checks++;
        if (fwd_e_rs !== 2'd2) begin n_fail++; $display("FAIL b2b_youngest: got %0d want 2", fwd_e_rs); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_d(1, 0, 1, 16, 2, 8);
        tick();
        set_d(8, 0, 0, 16, 3, 0);
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got %0b want 1", stall); end
        #1 rst_n = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (stall !== 1'b0 || fwd_d_rs !== 2'd0) begin
            n_fail++; $display("FAIL rst_mid_async: stall=%0b fwd=%0d want 0/0", stall, fwd_d_rs);
        end
        rst_n = 1'b1;
        #1;
        tick();
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_clean: got %0b want 0", stall); end
        idle();
    endtask

    function automatic int rnd_tuse();
        case ($urandom_range(0, 3))
            0: return 0;
            1: return 1;
            2: return 2;
            default: return 16;
        endcase
    endfunction

    task automatic test_random();
        int e_st, e_drs, e_drt, e_ers, e_ert, e_mrt;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_d(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), rnd_tuse(), rnd_tuse(),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 7)));
            e_st  = int'(m_stall());
            e_drs = m_fwd(int'(d_rs), 0);
            e_drt = m_fwd(int'(d_rt), 0);
            e_ers = m_fwd(hist[0].rs, 1);
            e_ert = m_fwd(hist[0].rt, 1);
            e_mrt = m_fwd(hist[1].rt, 2);
            n_checks++;
            if (int'(stall) != e_st) begin n_fail++; $display("FAIL rnd_stall c%0d: got %0b want %0d", c, stall, e_st); end
            n_checks++;
            if (int'(fwd_d_rs) != e_drs) begin n_fail++; $display("FAIL rnd_fwd_d_rs c%0d: got %0d want %0d", c, fwd_d_rs, e_drs); end
            n_checks++;
            if (int'(fwd_d_rt) != e_drt) begin n_fail++; $display("FAIL rnd_fwd_d_rt c%0d: got %0d want %0d", c, fwd_d_rt, e_drt); end
            n_checks++;
            if (int'(fwd_e_rs) != e_ers) begin n_fail++; $display("FAIL rnd_fwd_e_rs c%0d: got %0d want %0d", c, fwd_e_rs, e_ers); end
            n_checks++;
            if (int'(fwd_e_rt) != e_ert) begin n_fail++; $display("FAIL rnd_fwd_e_rt c%0d: got %0d want %0d", c, fwd_e_rt, e_ert); end
            n_checks++;
            if (int'(fwd_m_rt) != e_mrt) begin n_fail++; $display("FAIL rnd_fwd_m_rt c%0d: got %0d want %0d", c, fwd_m_rt, e_mrt); end
            tick();
        end
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        d_rs = '0; d_rt = '0; d_rs_tuse = 5'd16; d_rt_tuse = 5'd16; d_t = 5'd3; d_dst = '0;
        model_clear();
        #12;
        test_reset();
        test_lw_beq();
        test_alu_rtype();
        test_alu_beq();
        test_w_forward();
        test_lw_sw();
        test_zero_dst();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
